// File: rtl/hrm_cu_pkg.sv
// hrm_cu_pkg: shared definitions for the multi-channel HRM control unit.
// Holds the FSM state encodings, opcode values, muxR/aluCtl codes,
// the datapath control bundle and the channel-clamp helper.
package hrm_cu_pkg;

    typedef enum logic [4:0] {
        ST_RESET    = 5'd0,
        ST_FETCH_I  = 5'd1,
        ST_WAIT_KEY = 5'd2,
        ST_LOAD_IR  = 5'd3,
        ST_DECODE   = 5'd4,
        ST_INBOX    = 5'd5,
        ST_OUTBOX   = 5'd6,
        ST_INCPC2   = 5'd7,
        ST_FETCH_O  = 5'd8,
        ST_LOAD_AR  = 5'd9,
        ST_READMEM2 = 5'd10,
        ST_LOAD_AR2 = 5'd11,
        ST_READMEM  = 5'd12,
        ST_COPYFROM = 5'd13,
        ST_COPYTO   = 5'd14,
        ST_ADD      = 5'd15,
        ST_SUB      = 5'd16,
        ST_BUMPP    = 5'd17,
        ST_BUMPN    = 5'd18,
        ST_JUMP     = 5'd19,
        ST_JUMPZ    = 5'd20,
        ST_JUMPN    = 5'd21,
        ST_INC_PC   = 5'd22,
        ST_HALT     = 5'd23,
        ST_INVALID  = 5'd24
    } state_e;

    localparam logic [3:0] OP_INBOX    = 4'h0;
    localparam logic [3:0] OP_OUTBOX   = 4'h1;
    localparam logic [3:0] OP_COPYFROM = 4'h2;
    localparam logic [3:0] OP_COPYTO   = 4'h3;
    localparam logic [3:0] OP_ADD      = 4'h4;
    localparam logic [3:0] OP_SUB      = 4'h5;
    localparam logic [3:0] OP_BUMPP    = 4'h6;
    localparam logic [3:0] OP_BUMPN    = 4'h7;
    localparam logic [3:0] OP_JUMP     = 4'h8;
    localparam logic [3:0] OP_JUMPZ    = 4'h9;
    localparam logic [3:0] OP_JUMPN    = 4'hA;
    localparam logic [3:0] OP_HALT     = 4'hF;

    localparam logic [1:0] MUXR_NONE = 2'b00;
    localparam logic [1:0] MUXR_MEM  = 2'b01;
    localparam logic [1:0] MUXR_ALU  = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_INC = 3'b010;
    localparam logic [2:0] ALU_DEC = 3'b011;
    localparam logic [2:0] ALU_NEG = 3'b100;

    typedef struct packed {
        logic       wIR;
        logic       wR;
        logic       srcA;
        logic       wM;
        logic       wAR;
        logic       wPC;
        logic       rIn;
        logic       wO;
        logic       ijump;
        logic       branch;
        logic       rst;
        logic       halt;
        logic [1:0] muxR;
        logic [2:0] aluCtl;
    } ctl_t;

    // Out-of-range channel indices map onto the highest implemented channel.
    function automatic int unsigned ch_clamp(input int unsigned raw, input int unsigned nch);
        return (raw >= nch) ? nch - 1 : raw;
    endfunction

endpackage

// File: rtl/hrm_cu_stall_timer.sv
// hrm_cu_stall_timer: counts consecutive I/O stall cycles for the
// control-unit watchdog. Clear wins over enable; term_o is high once the
// count equals MAX and the count holds there until cleared.
module hrm_cu_stall_timer
    import hrm_cu_pkg::*;
#(
    parameter int MAX = 1,
    localparam int W = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign term_o = (cnt_q == W'(MAX));

    // Next count: clear, step while below the limit, else hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !term_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hrm_control_unit_mc.sv
// hrm_control_unit_mc: Moore control FSM of the HRM CPU with N-channel
// INBOX/OUTBOX selection, a bounded I/O stall watchdog and a
// retired-instruction counter.
// Optional feature macro: HRM_CU_STEP_EN adds the debug/nxtInstr
// single-step ports and the FETCH_I -> WAIT_KEY path.
module hrm_control_unit_mc
    import hrm_cu_pkg::*;
#(
    parameter int IW        = 8,
    parameter int NCH       = 1,
    parameter int STALL_MAX = 0,
    parameter int CNTW      = 16,
    localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            i_rst_n,
    input  logic [IW-1:0]   INSTR,
    input  logic [NCH-1:0]  inEmpty,
    input  logic [NCH-1:0]  outFull,
`ifdef HRM_CU_STEP_EN
    input  logic            debug,
    input  logic            nxtInstr,
`endif
    output logic            wIR,
    output logic            wR,
    output logic            srcA,
    output logic            wM,
    output logic            wAR,
    output logic            wPC,
    output logic            rIn,
    output logic            wO,
    output logic            ijump,
    output logic            branch,
    output logic            rst,
    output logic            halt,
    output logic [1:0]      muxR,
    output logic [2:0]      aluCtl,
    output logic [CHW-1:0]  chSel,
    output logic            stallErr,
    output logic [CNTW-1:0] retired
);

    state_e          state_q, state_d;
    logic [3:0]      opcode;
    logic            indirect;
    logic            in_blk, out_blk;
    logic            wd_limit, wd_trip, stall_loop;
    logic            stall_err_q;
    logic [CNTW-1:0] retired_q;
    ctl_t            ctl;
    logic            unused_bits;

    assign opcode   = INSTR[IW-1:IW-4];
    assign indirect = INSTR[IW-5];

    // Low instruction bits only matter when they carry a channel number.
    assign unused_bits = ^{INSTR, stall_loop};

    generate
        if (NCH > 1) begin : g_multi_ch
            logic [CHW-1:0] ch_raw;
            assign ch_raw  = INSTR[CHW-1:0];
            assign chSel   = CHW'(ch_clamp(32'(ch_raw), 32'(NCH)));
            assign in_blk  = inEmpty[chSel];
            assign out_blk = outFull[chSel];
        end else begin : g_single_ch
            assign chSel   = '0;
            assign in_blk  = inEmpty[0];
            assign out_blk = outFull[0];
        end
    endgenerate

    assign stall_loop = (state_q == ST_DECODE) && (state_d == ST_DECODE);

    generate
        if (STALL_MAX > 0) begin : g_watchdog
            hrm_cu_stall_timer #(
                .MAX (STALL_MAX)
            ) u_stall_timer (
                .clk    (clk),
                .rst_n  (i_rst_n),
                .clr_i  (state_d != ST_DECODE),
                .en_i   (stall_loop),
                .term_o (wd_limit)
            );
        end else begin : g_no_watchdog
            assign wd_limit = 1'b0;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; wd_trip flags a watchdog-forced halt.
    always_comb begin
        state_d = state_q;
        wd_trip = 1'b0;
        case (state_q)
            ST_RESET:    state_d = ST_FETCH_I;
`ifdef HRM_CU_STEP_EN
            ST_FETCH_I:  state_d = debug ? ST_WAIT_KEY : ST_LOAD_IR;
            ST_WAIT_KEY: if (nxtInstr) state_d = ST_LOAD_IR;
`else
            ST_FETCH_I:  state_d = ST_LOAD_IR;
`endif
            ST_LOAD_IR:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_INBOX: begin
                        // A limit hit beats a flag that drops on the same edge.
                        if (wd_limit) begin
                            state_d = ST_HALT;
                            wd_trip = 1'b1;
                        end else if (!in_blk) begin
                            state_d = ST_INBOX;
                        end
                    end
                    OP_OUTBOX: begin
                        if (wd_limit) begin
                            state_d = ST_HALT;
                            wd_trip = 1'b1;
                        end else if (!out_blk) begin
                            state_d = ST_OUTBOX;
                        end
                    end
                    OP_HALT: state_d = ST_HALT;
                    default: state_d = ST_INCPC2;
                endcase
            end
            ST_INCPC2:   state_d = ST_FETCH_O;
            ST_FETCH_O: begin
                case (opcode)
                    OP_JUMP:  state_d = ST_JUMP;
                    OP_JUMPZ: state_d = ST_JUMPZ;
                    OP_JUMPN: state_d = ST_JUMPN;
                    default:  state_d = ST_LOAD_AR;
                endcase
            end
            ST_LOAD_AR: begin
                if (indirect) begin
                    state_d = ST_READMEM2;
                end else if (opcode == OP_COPYTO) begin
                    state_d = ST_COPYTO;
                end else begin
                    state_d = ST_READMEM;
                end
            end
            ST_READMEM2: state_d = ST_LOAD_AR2;
            ST_LOAD_AR2: state_d = (opcode == OP_COPYTO) ? ST_COPYTO : ST_READMEM;
            ST_READMEM: begin
                case (opcode)
                    OP_BUMPP:    state_d = ST_BUMPP;
                    OP_BUMPN:    state_d = ST_BUMPN;
                    OP_COPYFROM: state_d = ST_COPYFROM;
                    OP_ADD:      state_d = ST_ADD;
                    OP_SUB:      state_d = ST_SUB;
                    default:     state_d = ST_HALT;
                endcase
            end
            ST_BUMPP, ST_BUMPN: state_d = ST_COPYTO;
            ST_COPYFROM, ST_COPYTO, ST_ADD, ST_SUB,
            ST_INBOX, ST_OUTBOX: state_d = ST_INC_PC;
            ST_INC_PC, ST_JUMP, ST_JUMPZ, ST_JUMPN: state_d = ST_FETCH_I;
            ST_HALT:     state_d = ST_HALT;
            default:     state_d = ST_INVALID;
        endcase
    end

    // Moore output decode: controls depend on the current state only.
    always_comb begin
        ctl = '0;
        case (state_q)
            ST_RESET:    ctl.rst = 1'b1;
            ST_LOAD_IR:  ctl.wIR = 1'b1;
            ST_INBOX: begin
                ctl.rIn = 1'b1;
                ctl.wR  = 1'b1;
            end
            ST_OUTBOX:   ctl.wO  = 1'b1;
            ST_INCPC2,
            ST_INC_PC:   ctl.wPC = 1'b1;
            ST_LOAD_AR:  ctl.wAR = 1'b1;
            ST_LOAD_AR2: begin
                ctl.srcA = 1'b1;
                ctl.wAR  = 1'b1;
            end
            ST_COPYFROM: begin
                ctl.muxR = MUXR_MEM;
                ctl.wR   = 1'b1;
            end
            ST_COPYTO:   ctl.wM = 1'b1;
            ST_ADD: begin
                ctl.muxR   = MUXR_ALU;
                ctl.aluCtl = ALU_ADD;
                ctl.wR     = 1'b1;
            end
            ST_SUB: begin
                ctl.muxR   = MUXR_ALU;
                ctl.aluCtl = ALU_SUB;
                ctl.wR     = 1'b1;
            end
            ST_BUMPP: begin
                ctl.muxR   = MUXR_ALU;
                ctl.aluCtl = ALU_INC;
                ctl.wR     = 1'b1;
            end
            ST_BUMPN: begin
                ctl.muxR   = MUXR_ALU;
                ctl.aluCtl = ALU_DEC;
                ctl.wR     = 1'b1;
            end
            ST_JUMP: begin
                ctl.branch = 1'b1;
                ctl.ijump  = 1'b1;
                ctl.wPC    = 1'b1;
            end
            ST_JUMPZ: begin
                ctl.branch = 1'b1;
                ctl.wPC    = 1'b1;
                ctl.aluCtl = ALU_ADD;
            end
            ST_JUMPN: begin
                ctl.branch = 1'b1;
                ctl.wPC    = 1'b1;
                ctl.aluCtl = ALU_NEG;
            end
            ST_HALT:     ctl.halt = 1'b1;
            default:     ctl = '0;
        endcase
    end

    // Sticky watchdog error; only reset clears it.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_err_q <= 1'b0;
        end else if (wd_trip) begin
            stall_err_q <= 1'b1;
        end
    end

    // Retired-instruction counter, bumped in each instruction's final state.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            retired_q <= '0;
        end else if (state_q inside {ST_INC_PC, ST_JUMP, ST_JUMPZ, ST_JUMPN}) begin
            retired_q <= retired_q + CNTW'(1);
        end
    end

    assign wIR      = ctl.wIR;
    assign wR       = ctl.wR;
    assign srcA     = ctl.srcA;
    assign wM       = ctl.wM;
    assign wAR      = ctl.wAR;
    assign wPC      = ctl.wPC;
    assign rIn      = ctl.rIn;
    assign wO       = ctl.wO;
    assign ijump    = ctl.ijump;
    assign branch   = ctl.branch;
    assign rst      = ctl.rst;
    assign halt     = ctl.halt;
    assign muxR     = ctl.muxR;
    assign aluCtl   = ctl.aluCtl;
    assign stallErr = stall_err_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_hrm_control_unit_mc.sv
// Testbench for hrm_control_unit_mc (NCH=3, STALL_MAX=8, CNTW=4).
// The reference model expands each instruction into its expected per-cycle
// control-signature sequence from the instruction-flow rules.
module tb_hrm_control_unit_mc;

    localparam int IW        = 8;
    localparam int NCH       = 3;
    localparam int STALL_MAX = 8;
    localparam int CNTW      = 4;

    localparam logic [16:0] S_WIR  = 17'h10000;
    localparam logic [16:0] S_WR   = 17'h08000;
    localparam logic [16:0] S_SRCA = 17'h04000;
    localparam logic [16:0] S_WM   = 17'h02000;
    localparam logic [16:0] S_WAR  = 17'h01000;
    localparam logic [16:0] S_WPC  = 17'h00800;
    localparam logic [16:0] S_RIN  = 17'h00400;
    localparam logic [16:0] S_WO   = 17'h00200;
    localparam logic [16:0] S_IJ   = 17'h00100;
    localparam logic [16:0] S_BR   = 17'h00080;
    localparam logic [16:0] S_RST  = 17'h00040;
    localparam logic [16:0] S_HLT  = 17'h00020;
    localparam logic [16:0] S_M11  = 17'h00018;
    localparam logic [16:0] S_M01  = 17'h00008;
    localparam logic [16:0] S_NONE = 17'h00000;

    logic            clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic [IW-1:0]   INSTR = '0;
    logic [NCH-1:0]  inEmpty = '0;
    logic [NCH-1:0]  outFull = '0;
`ifdef HRM_CU_STEP_EN
    logic            debug = 1'b0;
    logic            nxtInstr = 1'b0;
`endif
    logic wIR, wR, srcA, wM, wAR, wPC, rIn, wO, ijump, branch, rst, halt;
    logic [1:0]      muxR;
    logic [2:0]      aluCtl;
    logic [1:0]      chSel;
    logic            stallErr;
    logic [CNTW-1:0] retired;
    logic [16:0]     obs;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_ret = 0;

    typedef struct {
        logic [16:0] sig;
        bit          ret;
        bit          serr;
    } step_t;
    step_t q[$];

    always #5 clk = ~clk;

    assign obs = {wIR, wR, srcA, wM, wAR, wPC, rIn, wO, ijump, branch, rst, halt, muxR, aluCtl};

    hrm_control_unit_mc #(
        .IW(IW), .NCH(NCH), .STALL_MAX(STALL_MAX), .CNTW(CNTW)
    ) dut (
        .clk(clk), .i_rst_n(i_rst_n), .INSTR(INSTR),
        .inEmpty(inEmpty), .outFull(outFull),
`ifdef HRM_CU_STEP_EN
        .debug(debug), .nxtInstr(nxtInstr),
`endif
        .wIR(wIR), .wR(wR), .srcA(srcA), .wM(wM), .wAR(wAR), .wPC(wPC),
        .rIn(rIn), .wO(wO), .ijump(ijump), .branch(branch), .rst(rst),
        .halt(halt), .muxR(muxR), .aluCtl(aluCtl), .chSel(chSel),
        .stallErr(stallErr), .retired(retired)
    );

    task automatic push(input logic [16:0] s, input bit r, input bit e);
        step_t t;
        t.sig  = s;
        t.ret  = r;
        t.serr = e;
        q.push_back(t);
    endtask

    // Expected control sequence of one instruction from FETCH_I onward.
    // n = number of cycles the selected I/O flag stays blocked in DECODE.
    task automatic build_path(input logic [7:0] instr, input int n);
        int op;
        bit ind;
        op  = int'(instr[7:4]);
        ind = instr[3];
        q.delete();
        push(S_NONE, 0, 0);
        push(S_WIR, 0, 0);
        if (op <= 1) begin
            if (n >= STALL_MAX) begin
                for (int i = 0; i <= STALL_MAX; i++) push(S_NONE, 0, 0);
                push(S_HLT, 0, 1);
            end else begin
                for (int i = 0; i <= n; i++) push(S_NONE, 0, 0);
                push((op == 0) ? (S_RIN | S_WR) : S_WO, 0, 0);
                push(S_WPC, 1, 0);
            end
        end else if (op == 15) begin
            push(S_NONE, 0, 0);
            push(S_HLT, 0, 0);
        end else begin
            push(S_NONE, 0, 0);
            push(S_WPC, 0, 0);
            push(S_NONE, 0, 0);
            if (op == 8)       push(S_BR | S_IJ | S_WPC, 1, 0);
            else if (op == 9)  push(S_BR | S_WPC, 1, 0);
            else if (op == 10) push(S_BR | S_WPC | 17'd4, 1, 0);
            else begin
                push(S_WAR, 0, 0);
                if (ind) begin
                    push(S_NONE, 0, 0);
                    push(S_SRCA | S_WAR, 0, 0);
                end
                if (op == 3) begin
                    push(S_WM, 0, 0);
                    push(S_WPC, 1, 0);
                end else begin
                    push(S_NONE, 0, 0);
                    case (op)
                        2: begin push(S_WR | S_M01, 0, 0); push(S_WPC, 1, 0); end
                        4: begin push(S_WR | S_M11 | 17'd0, 0, 0); push(S_WPC, 1, 0); end
                        5: begin push(S_WR | S_M11 | 17'd1, 0, 0); push(S_WPC, 1, 0); end
                        6: begin push(S_WR | S_M11 | 17'd2, 0, 0); push(S_WM, 0, 0); push(S_WPC, 1, 0); end
                        7: begin push(S_WR | S_M11 | 17'd3, 0, 0); push(S_WM, 0, 0); push(S_WPC, 1, 0); end
                        default: push(S_HLT, 0, 0);
                    endcase
                end
            end
        end
    endtask

    // Drive one instruction and compare every cycle; stop_k >= 0 ends early.
    task automatic run_instr(input logic [7:0] instr, input int n, input int stop_k);
        int last;
        int ch;
        bit blk;
        build_path(instr, n);
        last = (stop_k >= 0) ? stop_k : q.size() - 1;
        ch = int'(instr[1:0]);
        if (ch >= NCH) ch = NCH - 1;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            if (k == 0) INSTR = instr;
            blk = (k >= 2) && (k < 2 + n);
            inEmpty = 3'($urandom);
            outFull = 3'($urandom);
            if (instr[7:4] == 4'h0) inEmpty[ch] = blk;
            else                    outFull[ch] = blk;
            #1;
            n_chk++;
            if (obs !== q[k].sig) begin
                n_fail++;
                $display("FAIL ctl instr=%h step=%0d got=%h want=%h", instr, k, obs, q[k].sig);
            end
            n_chk++;
            if (chSel !== 2'(ch)) begin
                n_fail++;
                $display("FAIL chsel instr=%h step=%0d got=%0d want=%0d", instr, k, chSel, ch);
            end
            n_chk++;
            if (retired !== CNTW'(exp_ret)) begin
                n_fail++;
                $display("FAIL retired instr=%h step=%0d got=%0d want=%0d", instr, k, retired, exp_ret);
            end
            n_chk++;
            if (stallErr !== q[k].serr) begin
                n_fail++;
                $display("FAIL stallerr instr=%h step=%0d got=%b want=%b", instr, k, stallErr, q[k].serr);
            end
            if (q[k].ret) exp_ret = (exp_ret + 1) % (1 << CNTW);
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        i_rst_n = 1'b0;
        inEmpty = '0;
        outFull = '0;
        @(negedge clk);
        @(negedge clk);
        i_rst_n = 1'b1;
        exp_ret = 0;
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        INSTR   = 8'h13;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_chk++;
        if (obs !== S_RST) begin n_fail++; $display("FAIL reset_ctl got=%h want=%h", obs, S_RST); end
        n_chk++;
        if (retired !== '0) begin n_fail++; $display("FAIL reset_retired got=%0d want=0", retired); end
        n_chk++;
        if (stallErr !== 1'b0) begin n_fail++; $display("FAIL reset_stallerr got=%b want=0", stallErr); end
        n_chk++;
        if (chSel !== 2'd2) begin n_fail++; $display("FAIL reset_chsel_clamp got=%0d want=2", chSel); end
        INSTR = 8'h11;
        #1;
        n_chk++;
        if (chSel !== 2'd1) begin n_fail++; $display("FAIL reset_chsel_follow got=%0d want=1", chSel); end
        i_rst_n = 1'b1;
        exp_ret = 0;
    endtask

    task automatic test_inbox_basic;
        run_instr(8'h00, 0, -1);
    endtask

    task automatic test_outbox_stall;
        run_instr(8'h12, 7, -1);
        run_instr(8'h03, 3, -1);
    endtask

    task automatic test_indirect_add;
        run_instr(8'h48, 0, -1);
        run_instr(8'h38, 0, -1);
        run_instr(8'h30, 0, -1);
    endtask

    task automatic test_random;
        logic [7:0] instr;
        int op;
        int n;
        for (int i = 0; i < 40; i++) begin
            op    = int'($urandom_range(10, 0));
            instr = {4'(op), 1'($urandom), 3'($urandom)};
            n     = (op <= 1) ? int'($urandom_range(STALL_MAX - 1, 0)) : 0;
            run_instr(instr, n, -1);
        end
    endtask

    task automatic test_reset_mid_jumpn;
        do_reset();
        run_instr(8'h20, 0, -1);
        run_instr(8'hA1, 0, 5);
        i_rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs !== S_RST) begin n_fail++; $display("FAIL midrst_ctl got=%h want=%h", obs, S_RST); end
        n_chk++;
        if (wPC !== 1'b0) begin n_fail++; $display("FAIL midrst_wpc got=%b want=0", wPC); end
        n_chk++;
        if (retired !== '0) begin n_fail++; $display("FAIL midrst_retired got=%0d want=0", retired); end
        @(posedge clk);
        #1;
        n_chk++;
        if (retired !== '0) begin n_fail++; $display("FAIL midrst_retired_hold got=%0d want=0", retired); end
        @(negedge clk);
        i_rst_n = 1'b1;
        exp_ret = 0;
    endtask

    task automatic test_watchdog(input int n);
        do_reset();
        run_instr(8'h01, n, -1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_chk++;
            if (obs !== S_HLT) begin n_fail++; $display("FAIL wd_halt_hold n=%0d got=%h want=%h", n, obs, S_HLT); end
            n_chk++;
            if (stallErr !== 1'b1) begin n_fail++; $display("FAIL wd_sticky n=%0d got=%b want=1", n, stallErr); end
        end
        i_rst_n = 1'b0;
        #1;
        n_chk++;
        if (stallErr !== 1'b0) begin n_fail++; $display("FAIL wd_clear got=%b want=0", stallErr); end
        @(negedge clk);
        i_rst_n = 1'b1;
        exp_ret = 0;
    endtask

    task automatic test_halt_paths;
        logic [7:0] ops [2];
        ops[0] = 8'hB5;
        ops[1] = 8'hF0;
        for (int j = 0; j < 2; j++) begin
            do_reset();
            run_instr(ops[j], 0, -1);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                #1;
                n_chk++;
                if (obs !== S_HLT) begin n_fail++; $display("FAIL halt_hold instr=%h got=%h want=%h", ops[j], obs, S_HLT); end
                n_chk++;
                if (stallErr !== 1'b0) begin n_fail++; $display("FAIL halt_no_err instr=%h got=%b want=0", ops[j], stallErr); end
            end
        end
    endtask

    task automatic test_step;
`ifdef HRM_CU_STEP_EN
        do_reset();
        INSTR    = 8'h20;
        debug    = 1'b1;
        nxtInstr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            n_chk++;
            if (obs !== S_NONE) begin n_fail++; $display("FAIL step_wait cyc=%0d got=%h want=%h", i, obs, S_NONE); end
        end
        @(negedge clk);
        nxtInstr = 1'b1;
        #1;
        n_chk++;
        if (obs !== S_NONE) begin n_fail++; $display("FAIL step_key got=%h want=%h", obs, S_NONE); end
        @(negedge clk);
        nxtInstr = 1'b0;
        #1;
        n_chk++;
        if (obs !== S_WIR) begin n_fail++; $display("FAIL step_loadir got=%h want=%h", obs, S_WIR); end
        debug = 1'b0;
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_inbox_basic();
        test_outbox_stall();
        test_indirect_add();
        test_random();
        test_reset_mid_jumpn();
        test_watchdog(STALL_MAX);
        test_watchdog(1000);
        test_halt_paths();
        test_step();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
